// File: rtl/jump_target_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jump_target_unit: registered ID-stage target/taken/link unit, optional    |
// | return-address stack enabled by macro JUMP_RAS_EN.        Revision: 1.0   |
// +--------------------------------------------------------------------------+
module jump_target_unit #(
  parameter int PC_SIZE        = 32,
  parameter int JUMP_ADDR_SIZE = 26,
  parameter int IMM_SIZE       = 16,
  parameter int LOWER_SIZE     = 2,
  parameter int RAS_DEPTH      = 4
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_flush,
  input  logic                      i_valid,
  input  logic [2:0]                i_mode,
  input  logic [JUMP_ADDR_SIZE-1:0] i_inst_index,
  input  logic [IMM_SIZE-1:0]       i_imm,
  input  logic [PC_SIZE-1:0]        i_next_pc,
  input  logic [PC_SIZE-1:0]        i_rs_data,
  input  logic [PC_SIZE-1:0]        i_rt_data,
  input  logic                      i_rs_is_ra,
  output logic                      o_valid,
  output logic                      o_taken,
  output logic [PC_SIZE-1:0]        o_target,
  output logic [PC_SIZE-1:0]        o_link_addr,
  output logic                      o_link_we,
  output logic                      o_misalign,
  output logic [PC_SIZE-1:0]        o_ras_pred,
  output logic                      o_ras_hit
);

  localparam int UPPER_SIZE = PC_SIZE - JUMP_ADDR_SIZE - LOWER_SIZE;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_J    = 3'd1,
    OP_JAL  = 3'd2,
    OP_JR   = 3'd3,
    OP_JALR = 3'd4,
    OP_BEQ  = 3'd5,
    OP_BNE  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  op_e                op;
  logic [PC_SIZE-1:0] jump_target;
  logic [PC_SIZE-1:0] imm_ext;
  logic [PC_SIZE-1:0] branch_target;
  logic               rs_misal;
  logic               do_push;
  logic               do_pop;

  logic               taken_d,    taken_q;
  logic [PC_SIZE-1:0] target_d,   target_q;
  logic               link_we_d,  link_we_q;
  logic               misalign_d, misalign_q;
  logic [PC_SIZE-1:0] ras_pred_d, ras_pred_q;
  logic               ras_hit_d,  ras_hit_q;
  logic               valid_q;
  logic [PC_SIZE-1:0] link_addr_q;

  assign jump_target   = {i_next_pc[PC_SIZE-1 -: UPPER_SIZE], i_inst_index, {LOWER_SIZE{1'b0}}};
  assign imm_ext       = {{(PC_SIZE-IMM_SIZE){i_imm[IMM_SIZE-1]}}, i_imm};
  assign branch_target = i_next_pc + (imm_ext << LOWER_SIZE);
  assign rs_misal      = |i_rs_data[LOWER_SIZE-1:0];

  always_comb begin
    op         = i_valid ? op_e'(i_mode) : OP_NONE;
    target_d   = '0;
    taken_d    = 1'b0;
    link_we_d  = 1'b0;
    misalign_d = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    case (op)
      OP_J: begin
        target_d = jump_target;
        taken_d  = 1'b1;
      end
      OP_JAL: begin
        target_d  = jump_target;
        taken_d   = 1'b1;
        link_we_d = 1'b1;
        do_push   = 1'b1;
      end
      OP_JR, OP_JALR: begin
        target_d   = i_rs_data;
        taken_d    = !rs_misal;
        misalign_d = rs_misal;
        link_we_d  = (op == OP_JALR);
        do_push    = (op == OP_JALR) && !rs_misal;
        do_pop     = i_rs_is_ra && !rs_misal;
      end
      OP_BEQ: begin
        target_d = branch_target;
        taken_d  = (i_rs_data == i_rt_data);
      end
      OP_BNE: begin
        target_d = branch_target;
        taken_d  = (i_rs_data != i_rt_data);
      end
      default: ;
    endcase
  end

`ifdef JUMP_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_SIZE-1:0] ras_mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]   top_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ras_upd;
  logic               ras_nonempty;
  logic [PC_SIZE-1:0] ras_top;

  assign ras_upd      = i_enable && !i_flush;
  assign ras_nonempty = (cnt_q != '0);
  assign ras_top      = ras_mem_q[top_q];
  assign ras_pred_d   = (do_pop && ras_nonempty) ? ras_top : '0;
  assign ras_hit_d    = do_pop && ras_nonempty && (ras_top == i_rs_data);

  // Pop+push on a non-empty stack collapses to an in-place replace of the top.
  always_ff @(posedge i_clock) begin
    if (ras_upd && do_push) begin
      if (do_pop && ras_nonempty) ras_mem_q[top_q] <= i_next_pc;
      else                        ras_mem_q[top_q + PTR_W'(1)] <= i_next_pc;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      top_q <= '0;
      cnt_q <= '0;
    end else if (ras_upd) begin
      if (do_push && !(do_pop && ras_nonempty)) begin
        top_q <= top_q + PTR_W'(1);
        if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_q <= cnt_q + CNT_W'(1);
      end else if (do_pop && !do_push && ras_nonempty) begin
        top_q <= top_q - PTR_W'(1);
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end
`else
  logic unused_ras;
  assign unused_ras = ^{do_push, do_pop, i_rs_is_ra};
  assign ras_pred_d = '0;
  assign ras_hit_d  = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      valid_q     <= 1'b0;
      taken_q     <= 1'b0;
      target_q    <= '0;
      link_addr_q <= '0;
      link_we_q   <= 1'b0;
      misalign_q  <= 1'b0;
      ras_pred_q  <= '0;
      ras_hit_q   <= 1'b0;
    end else if (i_enable) begin
      valid_q     <= i_valid;
      taken_q     <= taken_d;
      target_q    <= target_d;
      link_addr_q <= i_next_pc;
      link_we_q   <= link_we_d;
      misalign_q  <= misalign_d;
      ras_pred_q  <= ras_pred_d;
      ras_hit_q   <= ras_hit_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_taken     = taken_q;
  assign o_target    = target_q;
  assign o_link_addr = link_addr_q;
  assign o_link_we   = link_we_q;
  assign o_misalign  = misalign_q;
  assign o_ras_pred  = ras_pred_q;
  assign o_ras_hit   = ras_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_jump_target_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_jump_target_unit: directed + random checks against a reference model. |
// | RAS checks follow macro JUMP_RAS_EN.                      Revision: 1.0   |
// +--------------------------------------------------------------------------+
module tb_jump_target_unit;

  logic        clk = 1'b0;
  logic        rst, en, fl, v, ra;
  logic [2:0]  mode;
  logic [25:0] idx;
  logic [15:0] imm;
  logic [31:0] pc, rs, rt;
  logic        o_valid, o_taken, o_link_we, o_misalign, o_ras_hit;
  logic [31:0] o_target, o_link_addr, o_ras_pred;

  int total = 0;
  int bad   = 0;

  logic        e_valid, e_taken, e_link_we, e_mis, e_hit;
  logic [31:0] e_target, e_link, e_pred;
  logic [31:0] ras_q[$];

  always #5 clk = ~clk;

  jump_target_unit dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_flush(fl), .i_valid(v),
    .i_mode(mode), .i_inst_index(idx), .i_imm(imm), .i_next_pc(pc),
    .i_rs_data(rs), .i_rt_data(rt), .i_rs_is_ra(ra),
    .o_valid(o_valid), .o_taken(o_taken), .o_target(o_target),
    .o_link_addr(o_link_addr), .o_link_we(o_link_we), .o_misalign(o_misalign),
    .o_ras_pred(o_ras_pred), .o_ras_hit(o_ras_hit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: each op's architectural meaning, RAS as a bounded LIFO queue.
  task automatic model(input logic r, e, f, vv, input logic [2:0] m0, input logic [25:0] ix,
                       input logic [15:0] im, input logic [31:0] p, s, t, input logic a);
    int m;
    logic pop, push;
    logic [31:0] top;
    if (r) begin
      {e_valid, e_taken, e_link_we, e_mis, e_hit} = '0;
      e_target = 0; e_link = 0; e_pred = 0;
      ras_q.delete();
    end else if (f) begin
      {e_valid, e_taken, e_link_we, e_mis, e_hit} = '0;
      e_target = 0; e_link = 0; e_pred = 0;
    end else if (e) begin
      m = vv ? int'(m0) : 0;
      if (m == 7) m = 0;
      e_valid = vv;
      e_link = p;
      e_mis = (m == 3 || m == 4) && (s % 4 != 0);
      e_link_we = (m == 2 || m == 4);
      case (m)
        1, 2:    begin e_target = (p & 32'hF000_0000) + 32'(ix) * 4; e_taken = 1; end
        3, 4:    begin e_target = s; e_taken = !e_mis; end
        5:       begin e_target = p + 32'($signed(im) * 4); e_taken = (s == t); end
        6:       begin e_target = p + 32'($signed(im) * 4); e_taken = (s != t); end
        default: begin e_target = 0; e_taken = 0; end
      endcase
      e_pred = 0;
      e_hit  = 0;
`ifdef JUMP_RAS_EN
      pop  = (m == 3 || m == 4) && !e_mis && a;
      push = (m == 2) || (m == 4 && !e_mis);
      if (pop && ras_q.size() > 0) begin
        top = ras_q.pop_back();
        e_pred = top;
        e_hit  = (top == s);
      end
      if (push) begin
        ras_q.push_back(p);
        if (ras_q.size() > 4) void'(ras_q.pop_front());
      end
`else
      pop = a; push = 0;
      if (pop && push) e_pred = 0;
`endif
    end
  endtask

  task automatic check_all();
    chk("valid",    32'(o_valid),    32'(e_valid));
    chk("taken",    32'(o_taken),    32'(e_taken));
    chk("target",   o_target,        e_target);
    chk("link",     o_link_addr,     e_link);
    chk("link_we",  32'(o_link_we),  32'(e_link_we));
    chk("misalign", 32'(o_misalign), 32'(e_mis));
    chk("ras_pred", o_ras_pred,      e_pred);
    chk("ras_hit",  32'(o_ras_hit),  32'(e_hit));
  endtask

  task automatic step(input logic r, e, f, vv, input logic [2:0] m, input logic [25:0] ix,
                      input logic [15:0] im, input logic [31:0] p, s, t, input logic a);
    rst = r; en = e; fl = f; v = vv; mode = m; idx = ix; imm = im;
    pc = p; rs = s; rt = t; ra = a;
    @(posedge clk);
    model(r, e, f, vv, m, ix, im, p, s, t, a);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] held_t;
    logic [31:0] p, s;
    logic [2:0]  m;
    ras_q.delete();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 2, 26'h3, 16'h1, 32'h40, 32'h4, 0, 0);
    chk("reset_valid", 32'(o_valid), 0);
    chk("reset_target", o_target, 0);

    // J target composition
    step(0, 1, 0, 1, 1, 26'h0000123, 0, 32'h4000_0010, 0, 0, 0);
    chk("j_target", o_target, 32'h4000_048C);
    chk("j_taken", 32'(o_taken), 1);
    chk("j_link_we", 32'(o_link_we), 0);

    // branches
    step(0, 1, 0, 1, 5, 0, 16'hFFFE, 32'h0000_0100, 5, 5, 0);
    chk("beq_target", o_target, 32'h0000_00F8);
    chk("beq_taken", 32'(o_taken), 1);
    step(0, 1, 0, 1, 6, 0, 16'hFFFE, 32'h0000_0100, 5, 5, 0);
    chk("bne_taken", 32'(o_taken), 0);
    step(0, 1, 0, 1, 5, 0, 16'h7FFF, 32'hFFFF_FFFC, 5, 5, 0);
    chk("beq_wrap", o_target, 32'h0001_FFF8);

    // misaligned JALR
    step(0, 1, 0, 1, 4, 0, 0, 32'h0000_0200, 32'h0000_2002, 0, 0);
    chk("jalr_mis", 32'(o_misalign), 1);
    chk("jalr_mis_taken", 32'(o_taken), 0);
    chk("jalr_mis_we", 32'(o_link_we), 1);
    chk("jalr_mis_link", o_link_addr, 32'h0000_0200);

    // stall holds, then flush while stalled
    step(0, 1, 0, 1, 2, 26'h55, 0, 32'h0000_0300, 0, 0, 0);
    held_t = 32'h0000_0154;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 5, 26'h1, 16'h9, 32'h1234_0000, 1, 2, 0);
      chk("stall_target", o_target, held_t);
    end
    step(0, 0, 1, 1, 1, 26'h1, 0, 32'h0000_0500, 0, 0, 0);
    chk("flush_valid", 32'(o_valid), 0);

    // reset during a JAL, then JR $ra must not hit
    step(0, 1, 0, 1, 2, 0, 0, 32'h0000_0700, 0, 0, 0);
    step(1, 1, 0, 1, 2, 0, 0, 32'h0000_0800, 0, 0, 0);
    chk("rst_mid_we", 32'(o_link_we), 0);
    step(0, 1, 0, 1, 3, 0, 0, 32'h0000_0900, 32'h0000_0700, 0, 1);
    chk("rst_ras_hit", 32'(o_ras_hit), 0);

`ifdef JUMP_RAS_EN
    for (int i = 1; i <= 5; i++) step(0, 1, 0, 1, 2, 26'h10, 0, 32'(i * 16), 0, 0, 0);
    for (int i = 5; i >= 1; i--) begin
      step(0, 1, 0, 1, 3, 0, 0, 32'h0000_1000, 32'(i * 16), 0, 1);
      chk("ras_seq_hit", 32'(o_ras_hit), (i > 1) ? 1 : 0);
      chk("ras_seq_pred", o_ras_pred, (i > 1) ? 32'(i * 16) : 0);
    end
`endif

    for (int n = 0; n < 600; n++) begin
      p = 32'h0000_1000 + 32'($urandom_range(0, 7)) * 4;
      m = 3'($urandom_range(0, 7));
      s = ($urandom_range(0, 1) == 1) ? 32'h0000_1000 + 32'($urandom_range(0, 7)) * 4 : $urandom;
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0), m,
           26'($urandom), 16'($urandom), p, s,
           ($urandom_range(0, 1) == 1) ? s : $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jump_target_unit.md
Name: jump_target_unit

Overview:
- Parametrised successor to the ID-stage jump address register: one registered unit computing every control-transfer target (J, JAL, JR, JALR, BEQ, BNE), the taken decision, and the link address.
- Adds stall (enable), flush, operation-valid tracking, and misaligned-target detection.
- Optional return-address stack (RAS) predicts JR $ra targets.
- Sits in ID; outputs feed the IF PC mux and the register-file link write path.

Parameters:
- PC_SIZE, 32, PC and data width.
- JUMP_ADDR_SIZE, 26, instr_index field width in J-type instructions.
- IMM_SIZE, 16, branch immediate width.
- LOWER_SIZE, 2, zero bits appended to word offsets; UPPER_SIZE = PC_SIZE-JUMP_ADDR_SIZE-LOWER_SIZE, derived, not overridable.
- RAS_DEPTH, 4, RAS entries, power of two, >=2; used only with JUMP_RAS_EN.

Ports:
- i_clock  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  1 = advance; 0 = stall, hold all state.
- i_flush  in  1  squash the operation presented this cycle.
- i_valid  in  1  operation in ID is real.
- i_mode  in  3  0 NONE, 1 J, 2 JAL, 3 JR, 4 JALR, 5 BEQ, 6 BNE, 7 reserved.
- i_inst_index  in  JUMP_ADDR_SIZE  J-type target field.
- i_imm  in  IMM_SIZE  branch offset in words, signed.
- i_next_pc  in  PC_SIZE  PC+4 of the ID instruction.
- i_rs_data  in  PC_SIZE  forwarded rs value.
- i_rt_data  in  PC_SIZE  forwarded rt value.
- i_rs_is_ra  in  1  rs field == 31.
- o_valid  out  1  registered operation valid.
- o_taken  out  1  redirect PC to o_target.
- o_target  out  PC_SIZE  computed target.
- o_link_addr  out  PC_SIZE  return address (i_next_pc, no delay slot).
- o_link_we  out  1  write o_link_addr to the register file.
- o_misalign  out  1  JR/JALR target with bits[LOWER_SIZE-1:0] != 0.
- o_ras_pred  out  PC_SIZE  RAS top popped by this op.
- o_ras_hit  out  1  o_ras_pred == real JR target.

Behaviour:
- Priority: i_reset > i_flush > i_enable.
- Reset clears all outputs, RAS pointer and count to 0.
- Latency: 1 cycle; inputs sampled on an edge with i_enable=1 appear on the outputs after that edge.
- i_enable=0 and i_flush=0: outputs and RAS hold.
- i_flush=1, regardless of i_enable: next edge sets o_valid, o_taken, o_link_we, o_misalign, o_ras_hit to 0; o_target and o_link_addr also 0; RAS unchanged.
- Effective op = i_valid ? i_mode : NONE. Mode 7 is treated as NONE.
- Targets:
  - J/JAL: {i_next_pc[PC_SIZE-1:PC_SIZE-UPPER_SIZE], i_inst_index, LOWER_SIZE zeros}.
  - JR/JALR: i_rs_data.
  - BEQ/BNE: i_next_pc + (sign_extend(i_imm) << LOWER_SIZE), wrapping modulo 2^PC_SIZE.
  - NONE: target 0.
- Taken:
  - J/JAL: always taken.
  - JR/JALR: taken unless misaligned; misaligned gives o_taken=0, o_misalign=1.
  - BEQ: taken when rs==rt. BNE: taken when rs!=rt.
- o_link_we=1 for JAL and JALR, including misaligned JALR. o_link_addr=i_next_pc for all ops.
- o_valid=i_valid for every mode, including NONE.

Optional Feature:
- Macro JUMP_RAS_EN.
- Defined:
  - Circular stack of RAS_DEPTH entries with top pointer and saturating count (0..RAS_DEPTH).
  - Push i_next_pc on JAL, and on aligned JALR.
  - Pop on aligned JR/JALR with i_rs_is_ra=1.
  - Same-edge pop and push (JALR $ra): top entry is replaced; count unchanged.
  - Push when full: overwrites the oldest entry; count stays RAS_DEPTH.
  - Pop when empty: o_ras_pred=0, o_ras_hit=0, count stays 0.
  - o_ras_pred = popped entry; o_ras_hit = (popped entry == i_rs_data) and count>0. Both are 0 for non-popping ops.
  - RAS updates only on non-flushed, enabled edges.
- Undefined: no RAS storage; o_ras_pred and o_ras_hit tied to 0.

Test Plan:
- Reset mid-operation: JAL in flight, assert i_reset one cycle -> all outputs 0 next cycle; with JUMP_RAS_EN, a following JR $ra gives o_ras_hit=0.
- J: i_next_pc=0x4000_0010, i_inst_index=0x0000123 -> o_target=0x4000_048C, o_taken=1, o_link_we=0.
- BEQ/BNE at i_next_pc=0x0000_0100:
  - BEQ, i_imm=0xFFFE, rs=rt=5 -> o_target=0x0000_00F8, o_taken=1.
  - BNE with same operands -> o_taken=0.
  - BEQ, i_imm=0x7FFF, i_next_pc=0xFFFF_FFFC -> target wraps to 0x0001_FFF8.
- JALR misaligned: rs=0x0000_2002 -> o_misalign=1, o_taken=0, o_link_we=1, o_link_addr=i_next_pc.
- Stall/flush: JAL, then i_enable=0 for 3 cycles -> outputs held. Flush with i_enable=0 -> o_valid=0 next cycle.
- JUMP_RAS_EN, RAS_DEPTH=4:
  - 5 JALs at next_pc 0x10, 0x20, 0x30, 0x40, 0x50, then 5 JR $ra with matching rs.
  - First 4 pops -> hits 0x50, 0x40, 0x30, 0x20; the 0x10 entry was overwritten.
  - 5th pop: empty -> o_ras_hit=0.
